// File: rtl/dadda_mul_arbiter_pkg.sv
// Shared types and widths for the shared-multiplier arbiter.
package dadda_mul_arbiter_pkg;

    localparam int OPW = 8;
    localparam int PRW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dadda_mul_arbiter_dadda.sv
// Combinational 8x8 unsigned Dadda multiplier: column reduction to heights 6,4,3,2, then one final adder.
module dadda_8x8
    import dadda_mul_arbiter_pkg::*;
(
    output logic [PRW-1:0] s,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b
);

    localparam int NCOL = PRW;
    localparam int MAXH = 16;

    always_comb begin : reduce
        logic           cur [NCOL][MAXH];
        logic           nxt [NCOL][MAXH];
        int             hc  [NCOL];
        int             hn  [NCOL];
        int             idx;
        int             m;
        int             d;
        logic [PRW-1:0] row0;
        logic [PRW-1:0] row1;

        idx  = 0;
        m    = 0;
        d    = 0;
        row0 = '0;
        row1 = '0;
        for (int c = 0; c < NCOL; c++) begin
            hc[c] = 0;
            hn[c] = 0;
            for (int k = 0; k < MAXH; k++) begin
                cur[c][k] = 1'b0;
                nxt[c][k] = 1'b0;
            end
        end

        for (int i = 0; i < OPW; i++) begin
            for (int j = 0; j < OPW; j++) begin
                cur[i+j][hc[i+j]] = a[i] & b[j];
                hc[i+j]++;
            end
        end

        // Each stage only adds enough full/half adders to bring every column down to d.
        for (int st = 0; st < 4; st++) begin
            d = (st == 0) ? 6 : (st == 1) ? 4 : (st == 2) ? 3 : 2;
            for (int c = 0; c < NCOL; c++) begin
                hn[c] = 0;
                for (int k = 0; k < MAXH; k++) nxt[c][k] = 1'b0;
            end
            for (int c = 0; c < NCOL; c++) begin
                idx = 0;
                m   = hn[c];
                for (int r = 0; r < 8; r++) begin
                    if (hc[c] - idx + m > d) begin
                        if ((hc[c] - idx + m - d >= 2) && (hc[c] - idx >= 3)) begin
                            nxt[c][m] = cur[c][idx] ^ cur[c][idx+1] ^ cur[c][idx+2];
                            if (c < NCOL - 1) begin
                                nxt[c+1][hn[c+1]] = (cur[c][idx] & cur[c][idx+1]) |
                                                    (cur[c][idx] & cur[c][idx+2]) |
                                                    (cur[c][idx+1] & cur[c][idx+2]);
                                hn[c+1]++;
                            end
                            idx += 3;
                            m++;
                        end else if (hc[c] - idx >= 2) begin
                            nxt[c][m] = cur[c][idx] ^ cur[c][idx+1];
                            if (c < NCOL - 1) begin
                                nxt[c+1][hn[c+1]] = cur[c][idx] & cur[c][idx+1];
                                hn[c+1]++;
                            end
                            idx += 2;
                            m++;
                        end
                    end
                end
                for (int k = 0; k < MAXH; k++) begin
                    if (k >= idx && k < hc[c]) begin
                        nxt[c][m] = cur[c][k];
                        m++;
                    end
                end
                hn[c] = m;
            end
            cur = nxt;
            hc  = hn;
        end

        for (int c = 0; c < NCOL; c++) begin
            row0[c] = (hc[c] > 0) ? cur[c][0] : 1'b0;
            row1[c] = (hc[c] > 1) ? cur[c][1] : 1'b0;
        end
        s = row0 + row1;
    end

endmodule

// File: rtl/dadda_mul_arbiter_rr_grant.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NREQ.
module rr_grant #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic            gnt_valid,
    output logic [IDW-1:0]  gnt_id,
    output logic [NREQ-1:0] gnt_onehot
);

    always_comb begin
        int cand;
        gnt_valid  = 1'b0;
        gnt_id     = '0;
        gnt_onehot = '0;
        cand       = 0;
        // Walk from farthest to nearest so the nearest active requester wins.
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(last) + k) % NREQ;
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_id    = IDW'(cand);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            gnt_onehot[i] = gnt_valid && (gnt_id == IDW'(i));
        end
    end

endmodule

// File: rtl/dadda_mul_arbiter.sv
// Round-robin arbiter sharing one registered-in/registered-out Dadda multiplier among NREQ requesters.
module dadda_mul_arbiter
    import dadda_mul_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_a,
    input  logic [NREQ*OPW-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [PRW-1:0]      rsp_data,
    output logic                busy,
    output logic [15:0]         op_count
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid may not depend on ready, ready may depend on valid, and a producer holds its
    // payload stable while valid is high and ready is low.

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] last;
    logic [IDW-1:0] op_id;
    logic [OPW-1:0] op_a;
    logic [OPW-1:0] op_b;
    logic [PRW-1:0] product;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic [NREQ-1:0] gnt_onehot;
    logic           take_req;
    logic           take_rsp;

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_grant (
        .req        (req_valid),
        .last       (last),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id),
        .gnt_onehot (gnt_onehot)
    );

    dadda_8x8 u_mul (
        .s (product),
        .a (op_a),
        .b (op_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready is gated by reset so nothing looks granted while the block is being cleared.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        take_req  = 1'b0;
        take_rsp  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst_n && gnt_valid) begin
                    req_ready = gnt_onehot;
                    take_req  = 1'b1;
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    take_rsp  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last      <= IDW'(NREQ - 1);
            op_id     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            op_count  <= '0;
        end else begin
            if (take_req) begin
                op_a  <= req_a[gnt_id*OPW +: OPW];
                op_b  <= req_b[gnt_id*OPW +: OPW];
                op_id <= gnt_id;
                last  <= gnt_id;
            end
            if (state == ST_CALC) begin
                rsp_data  <= product;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end
            if (take_rsp) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + 16'd1;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
